// File: rtl/minute_interval_timer.sv
// Minute interval timer: prescaler divides CLK into minute ticks, a down-counter times a phase.
// Supports run/pause/stop, explicit load, optional auto-reload, and sticky or pulsed done.
module minute_interval_timer #(
    parameter int unsigned PRESCALE = 30,
    parameter int unsigned PRE_W    = 5,
    parameter int unsigned MIN_W    = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Load,
    input  logic [MIN_W-1:0] Duration,
    input  logic [1:0]       TimerMode,
    input  logic             AutoReload,
    output logic             MinTick,
    output logic [MIN_W-1:0] Remaining,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {StIdle, StRunning, StPaused, StExpired} state_e;

    localparam logic [PRE_W-1:0] PreLast = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PreOne  = PRE_W'(1);
    localparam logic [MIN_W-1:0] MinOne  = MIN_W'(1);

    state_e             state_q;
    logic [PRE_W-1:0]   pre_q;
    logic [MIN_W-1:0]   rem_q;
    logic [MIN_W-1:0]   dur_q;
    logic               tick_q;
    logic               busy_q;
    logic               done_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= StIdle;
            pre_q   <= '0;
            rem_q   <= '0;
            dur_q   <= '0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (Load) begin
            dur_q  <= Duration;
            rem_q  <= Duration;
            pre_q  <= '0;
            tick_q <= 1'b0;
            if (Duration != '0) begin
                state_q <= StRunning;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end else begin
                state_q <= StExpired;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end else if (TimerMode[1]) begin
            // STOP and the reserved 11 encoding both abandon the interval; dur_q is kept.
            state_q <= StIdle;
            pre_q   <= '0;
            rem_q   <= '0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StRunning, StPaused: begin
                    tick_q <= 1'b0;
                    done_q <= 1'b0;
                    busy_q <= 1'b1;
                    if (TimerMode[0]) begin
                        state_q <= StPaused;
                    end else begin
                        state_q <= StRunning;
                        if (pre_q >= PreLast) begin
                            pre_q  <= '0;
                            tick_q <= 1'b1;
                            if (rem_q <= MinOne) begin
                                done_q <= 1'b1;
                                if (AutoReload) begin
                                    rem_q <= dur_q;
                                end else begin
                                    rem_q   <= '0;
                                    busy_q  <= 1'b0;
                                    state_q <= StExpired;
                                end
                            end else begin
                                rem_q <= rem_q - MinOne;
                            end
                        end else begin
                            pre_q <= pre_q + PreOne;
                        end
                    end
                end
                default: begin
                    // Idle/expired hold everything except the tick pulse.
                    tick_q <= 1'b0;
                end
            endcase
        end
    end

    assign MinTick   = tick_q;
    assign Remaining = rem_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_minute_interval_timer.sv
// Self-checking bench for minute_interval_timer: directed scenarios plus randomized stimulus
// against a behavioural model of remaining minutes, elapsed run edges and flags.
module tb_minute_interval_timer;

    localparam int unsigned PRESCALE = 4;
    localparam int unsigned PRE_W    = 3;
    localparam int unsigned MIN_W    = 4;

    logic             CLK;
    logic             RST;
    logic             Load;
    logic [MIN_W-1:0] Duration;
    logic [1:0]       TimerMode;
    logic             AutoReload;
    logic             MinTick;
    logic [MIN_W-1:0] Remaining;
    logic             Busy;
    logic             Done;

    minute_interval_timer #(
        .PRESCALE (PRESCALE),
        .PRE_W    (PRE_W),
        .MIN_W    (MIN_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Load       (Load),
        .Duration   (Duration),
        .TimerMode  (TimerMode),
        .AutoReload (AutoReload),
        .MinTick    (MinTick),
        .Remaining  (Remaining),
        .Busy       (Busy),
        .Done       (Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: an interval is "active" while busy; runs counts RUN edges into the current minute.
    int m_rem  = 0;
    int m_dur  = 0;
    int m_runs = 0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    bit m_tick = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge CLK) begin
        m_tick = 1'b0;
        if (!RST) begin
            m_rem = 0; m_dur = 0; m_runs = 0; m_busy = 1'b0; m_done = 1'b0;
        end else if (Load) begin
            m_dur  = int'(Duration);
            m_rem  = int'(Duration);
            m_runs = 0;
            m_busy = (Duration != 0);
            m_done = (Duration == 0);
        end else if (TimerMode >= 2) begin
            m_rem = 0; m_runs = 0; m_busy = 1'b0; m_done = 1'b0;
        end else if (m_busy) begin
            m_done = 1'b0;
            if (TimerMode == 0) begin
                m_runs++;
                if (m_runs == PRESCALE) begin
                    m_runs = 0;
                    m_tick = 1'b1;
                    m_rem--;
                    if (m_rem == 0) begin
                        m_done = 1'b1;
                        if (AutoReload) m_rem = m_dur;
                        else m_busy = 1'b0;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_MinTick", int'(MinTick), int'(m_tick));
            check("model_Remaining", int'(Remaining), m_rem);
            check("model_Busy", int'(Busy), int'(m_busy));
            check("model_Done", int'(Done), int'(m_done));
        end
    end

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic run(input int n, output int ticks, output int dones);
        ticks = 0;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (MinTick) ticks++;
            if (Done) dones++;
        end
    endtask

    task automatic do_load(input int d);
        Load = 1'b1;
        Duration = MIN_W'(d);
        step();
        Load = 1'b0;
    endtask

    int nt;
    int nd;
    int r;

    initial begin
        RST = 1'b0; Load = 1'b0; Duration = '0; TimerMode = 2'b00; AutoReload = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        check("reset_busy", int'(Busy), 0);
        check("reset_done", int'(Done), 0);
        check("reset_rem", int'(Remaining), 0);
        RST = 1'b1;

        // 1: one-shot D=3, ticks at 4/8/12, sticky done
        do_load(3);
        nt = 0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (MinTick) nt++;
            if (e == 4)  check("t1_tick4_rem", int'(Remaining), 2);
            if (e == 8)  check("t1_tick8", int'(MinTick), 1);
            if (e == 11) check("t1_e11_done", int'(Done), 0);
        end
        check("t1_tick12", int'(MinTick), 1);
        check("t1_ticks", nt, 3);
        check("t1_done", int'(Done), 1);
        check("t1_busy", int'(Busy), 0);
        run(10, nt, nd);
        check("t1_hold_done", int'(Done), 1);
        check("t1_hold_ticks", nt, 0);

        // 2: pause keeps partial minute
        do_load(2);
        run(2, nt, nd);
        TimerMode = 2'b01;
        run(5, nt, nd);
        check("t2_pause_rem", int'(Remaining), 2);
        check("t2_pause_busy", int'(Busy), 1);
        check("t2_pause_ticks", nt, 0);
        TimerMode = 2'b00;
        step();
        check("t2_resume1", int'(MinTick), 0);
        step();
        check("t2_resume2_tick", int'(MinTick), 1);
        check("t2_resume2_rem", int'(Remaining), 1);
        run(3, nt, nd);
        check("t2_not_done", int'(Done), 0);
        step();
        check("t2_done", int'(Done), 1);
        check("t2_idle", int'(Busy), 0);

        // 3: auto-reload pulses done every 8 edges
        AutoReload = 1'b1;
        do_load(2);
        nd = 0;
        for (int e = 1; e <= 24; e++) begin
            step();
            if (Done) nd++;
            if (e % 8 == 0) check("t3_done_pulse", int'(Done), 1);
            if (e == 8) check("t3_reload_rem", int'(Remaining), 2);
        end
        check("t3_dones", nd, 3);
        check("t3_busy", int'(Busy), 1);
        AutoReload = 1'b0;

        // 4: stop and reserved mode
        do_load(5);
        run(6, nt, nd);
        TimerMode = 2'b10;
        step();
        check("t4_stop_rem", int'(Remaining), 0);
        check("t4_stop_busy", int'(Busy), 0);
        check("t4_stop_done", int'(Done), 0);
        TimerMode = 2'b00;
        run(20, nt, nd);
        check("t4_no_ticks", nt, 0);
        do_load(5);
        run(6, nt, nd);
        TimerMode = 2'b11;
        step();
        check("t4_m11_rem", int'(Remaining), 0);
        check("t4_m11_busy", int'(Busy), 0);
        TimerMode = 2'b00;

        // 5: zero duration, then reload mid-minute
        do_load(0);
        check("t5_zero_done", int'(Done), 1);
        check("t5_zero_busy", int'(Busy), 0);
        check("t5_zero_rem", int'(Remaining), 0);
        do_load(4);
        run(2, nt, nd);
        do_load(4);
        run(3, nt, nd);
        check("t5_no_early_tick", nt, 0);
        step();
        check("t5_tick", int'(MinTick), 1);
        check("t5_rem", int'(Remaining), 3);
        check("t5_done_clr", int'(Done), 0);

        // 6: reset mid-count
        do_load(3);
        run(2, nt, nd);
        RST = 1'b0;
        step();
        check("t6_rst_rem", int'(Remaining), 0);
        check("t6_rst_busy", int'(Busy), 0);
        check("t6_rst_tick", int'(MinTick), 0);
        RST = 1'b1;
        run(20, nt, nd);
        check("t6_no_ticks", nt, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            RST = ($urandom_range(0, 299) != 0);
            Load = ($urandom_range(0, 24) == 0);
            Duration = MIN_W'($urandom_range(0, 15));
            r = $urandom_range(0, 19);
            if (r < 16) TimerMode = 2'b00;
            else if (r < 19) TimerMode = 2'b01;
            else TimerMode = 2'($urandom_range(2, 3));
            if ($urandom_range(0, 49) == 0) AutoReload = ~AutoReload;
            step();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
